// File: rtl/sp_eval_multi_if.sv
// Shared types and the OAM / CHR / line-buffer bus of the multi-sprite evaluator.
package sp_eval_multi_pkg;
    typedef enum logic {
        LEFT_TBL  = 1'b0,
        RIGHT_TBL = 1'b1
    } pattern_tbl_t;

    typedef struct packed {
        logic       active;
        logic [7:0] y_pos;
        logic [7:0] tile_idx;
        logic [7:0] attribute;
        logic [7:0] x_pos;
        logic [7:0] bitmap_hi;
        logic [7:0] bitmap_lo;
    } second_oam_t;

    typedef struct packed {
        logic [7:0] y_pos;
        logic [7:0] tile_idx;
        logic [7:0] attribute;
        logic [7:0] x_pos;
    } spr_entry_t;
endpackage

interface sp_eval_multi_if #(
    parameter int unsigned MAX_SPR = 8
);
    localparam int unsigned IDX_W = (MAX_SPR > 1) ? $clog2(MAX_SPR) : 1;

    logic [7:0]                       oam_addr;
    logic [7:0]                       oam_data;
    logic [12:0]                      chr_addr_lo;
    logic [12:0]                      chr_addr_hi;
    logic                             chr_re;
    logic [7:0]                       chr_data_lo;
    logic [7:0]                       chr_data_hi;
    logic                             line_wr;
    logic [IDX_W-1:0]                 line_wr_idx;
    sp_eval_multi_pkg::second_oam_t   line_wr_data;

    modport master (
        output oam_addr,
        input  oam_data,
        output chr_addr_lo, chr_addr_hi, chr_re,
        input  chr_data_lo, chr_data_hi,
        output line_wr, line_wr_idx, line_wr_data
    );

    modport slave (
        input  oam_addr,
        output oam_data,
        input  chr_addr_lo, chr_addr_hi, chr_re,
        output chr_data_lo, chr_data_hi,
        input  line_wr, line_wr_idx, line_wr_data
    );
endinterface

// File: rtl/sp_eval_multi.sv
// Per-scanline sprite evaluator: scans OAM, buffers up to MAX_SPR hits,
// fetches their bitplanes and writes every slot to the sprite line buffer.
module sp_eval_multi
    import sp_eval_multi_pkg::*;
#(
    parameter int unsigned MAX_SPR = 8,
    parameter int unsigned NUM_OAM = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clk_en,
    input  logic [8:0]      i_row,
    input  logic [8:0]      i_col,
    input  logic            i_tall_mode,
    input  pattern_tbl_t    i_patt_tbl,
    sp_eval_multi_if.master bus,
    output logic            o_spr_overflow,
    output logic            o_spr0_on_line
);
    localparam int unsigned IDX_W      = (MAX_SPR > 1) ? $clog2(MAX_SPR) : 1;
    localparam int unsigned CNT_W      = $clog2(MAX_SPR + 1);
    localparam int unsigned OAM_IDX_W  = $clog2(NUM_OAM);
    localparam int unsigned FETCH_LAST = 256 + 2 * MAX_SPR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    spr_entry_t       r_buf [MAX_SPR];
    logic [7:0]       r_cur_y;
    logic [7:0]       r_cur_tile;
    logic [7:0]       r_cur_attr;
    logic             r_hit;
    logic             r_spr0_cand;
    logic             r_tall;
    logic             r_ovf;
    logic             r_spr0;

    // Scan-phase decode: dot 1+4n+b reads byte b of sprite n
    logic [7:0]           w_scan_off;
    logic [1:0]           w_byte;
    logic [OAM_IDX_W-1:0] w_sprite;
    logic [8:0]           w_height;
    logic [8:0]           w_diff;
    logic                 w_in_range;
    logic                 w_collect;
    logic                 w_has_room;
    logic                 w_eval_row;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;

    assign w_scan_off = 8'(i_col - 9'd1);
    assign w_byte     = w_scan_off[1:0];
    assign w_sprite   = w_scan_off[7:2];
    assign w_height   = r_tall ? 9'd16 : 9'd8;
    assign w_diff     = i_row - {1'b0, bus.oam_data};
    assign w_in_range = (w_diff < w_height);
    assign w_collect  = (i_row != 9'd261);
    assign w_has_room = (r_count < CNT_W'(MAX_SPR));
    assign w_eval_row = (i_row <= 9'd239) || (i_row == 9'd261);
    assign w_ovf_set  = (r_state == SCAN) && (w_byte == 2'd0) && w_collect
                        && w_in_range && !w_has_room;
    assign w_ovf_clr  = (i_row == 9'd261) && (i_col == 9'd1);

    // Fetch-phase decode: slot k addresses on dot 257+2k, writes on 258+2k
    logic [8:0]       w_fetch_off;
    logic [7:0]       w_slot;
    logic [IDX_W-1:0] w_idx;
    logic             w_active;
    spr_entry_t       w_ent;
    logic [3:0]       w_r;
    logic [3:0]       w_rf;
    logic [12:0]      w_base;
    logic [12:0]      w_addr_8;
    logic [12:0]      w_addr_16;
    logic [12:0]      w_addr_lo;

    assign w_fetch_off = i_col - 9'd257;
    assign w_slot      = w_fetch_off[8:1];
    assign w_idx       = IDX_W'(w_slot);
    assign w_active    = ({1'b0, w_slot} < 9'(r_count));
    assign w_ent       = r_buf[w_idx];
    assign w_r         = i_row[3:0] - w_ent.y_pos[3:0];
    assign w_rf        = w_ent.attribute[7] ? ((r_tall ? 4'd15 : 4'd7) - w_r) : w_r;
    assign w_base      = (i_patt_tbl == RIGHT_TBL) ? 13'h1000 : 13'h0000;
    assign w_addr_8    = w_base + {1'b0, w_ent.tile_idx, 1'b0, w_rf[2:0]};
    assign w_addr_16   = {w_ent.tile_idx[0], w_ent.tile_idx[7:1], w_rf[3], 1'b0, w_rf[2:0]};
    assign w_addr_lo   = r_tall ? w_addr_16 : w_addr_8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_cur_y     <= '0;
            r_cur_tile  <= '0;
            r_cur_attr  <= '0;
            r_hit       <= 1'b0;
            r_spr0_cand <= 1'b0;
            r_tall      <= 1'b0;
            r_ovf       <= 1'b0;
            r_spr0      <= 1'b0;
            for (int k = 0; k < int'(MAX_SPR); k++) r_buf[k] <= '0;
        end else if (i_clk_en) begin
            // Clear has priority over a same-cycle set
            if (w_ovf_clr)      r_ovf <= 1'b0;
            else if (w_ovf_set) r_ovf <= 1'b1;

            unique case (r_state)
                IDLE: begin
                    if ((i_col == 9'd0) && w_eval_row) begin
                        r_state     <= SCAN;
                        r_count     <= '0;
                        r_spr0_cand <= 1'b0;
                        r_hit       <= 1'b0;
                        r_tall      <= i_tall_mode;
                    end
                end
                SCAN: begin
                    unique case (w_byte)
                        2'd0: begin
                            r_hit <= w_collect && w_in_range && w_has_room;
                            r_cur_y <= bus.oam_data;
                        end
                        2'd1: r_cur_tile <= bus.oam_data;
                        2'd2: r_cur_attr <= bus.oam_data;
                        default: begin
                            if (r_hit) begin
                                r_buf[IDX_W'(r_count)] <= '{y_pos:     r_cur_y,
                                                           tile_idx:  r_cur_tile,
                                                           attribute: r_cur_attr,
                                                           x_pos:     bus.oam_data};
                                r_count <= r_count + CNT_W'(1);
                                if (w_sprite == '0) r_spr0_cand <= 1'b1;
                            end
                        end
                    endcase
                    if (i_col == 9'd256) begin
                        r_state <= FETCH;
                        r_spr0  <= r_spr0_cand;
                    end
                end
                FETCH: begin
                    if (i_col == 9'(FETCH_LAST)) r_state <= DONE;
                end
                default: begin
                    if (i_col == 9'd340) r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus drive: OAM address while scanning, CHR read / slot write while fetching
    always_comb begin
        bus.oam_addr     = '0;
        bus.chr_addr_lo  = '0;
        bus.chr_addr_hi  = '0;
        bus.chr_re       = 1'b0;
        bus.line_wr      = 1'b0;
        bus.line_wr_idx  = '0;
        bus.line_wr_data = '0;
        if (r_state == SCAN) bus.oam_addr = w_scan_off;
        if (r_state == FETCH) begin
            bus.chr_addr_lo = w_addr_lo;
            bus.chr_addr_hi = w_addr_lo + 13'd8;
            bus.chr_re      = !w_fetch_off[0];
            bus.line_wr     = w_fetch_off[0];
            if (w_fetch_off[0]) begin
                bus.line_wr_idx = w_idx;
                if (w_active) begin
                    bus.line_wr_data = '{active:    1'b1,
                                         y_pos:     w_ent.y_pos,
                                         tile_idx:  w_ent.tile_idx,
                                         attribute: w_ent.attribute,
                                         x_pos:     w_ent.x_pos,
                                         bitmap_hi: bus.chr_data_hi,
                                         bitmap_lo: bus.chr_data_lo};
                end
            end
        end
    end

    assign o_spr_overflow = r_ovf;
    assign o_spr0_on_line = r_spr0;
endmodule

// File: tb/tb_sp_eval_multi.sv
// Directed bench for sp_eval_multi: two instances (8 and 16 slots) share one OAM image.
module tb_sp_eval_multi;
    import sp_eval_multi_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic [8:0]   row;
    logic [8:0]   col;
    logic         tall;
    pattern_tbl_t patt;
    logic         ovf8, spr0_8, ovf16, spr0_16;

    int total = 0;
    int bad   = 0;

    logic [7:0] oam [256];

    sp_eval_multi_if #(.MAX_SPR(8))  bus8 ();
    sp_eval_multi_if #(.MAX_SPR(16)) bus16 ();

    sp_eval_multi #(.MAX_SPR(8), .NUM_OAM(64)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_row(row), .i_col(col),
        .i_tall_mode(tall), .i_patt_tbl(patt), .bus(bus8),
        .o_spr_overflow(ovf8), .o_spr0_on_line(spr0_8)
    );

    sp_eval_multi #(.MAX_SPR(16), .NUM_OAM(64)) dut16 (
        .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_row(row), .i_col(col),
        .i_tall_mode(tall), .i_patt_tbl(patt), .bus(bus16),
        .o_spr_overflow(ovf16), .o_spr0_on_line(spr0_16)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chr_f(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    assign bus8.oam_data  = oam[bus8.oam_addr];
    assign bus16.oam_data = oam[bus16.oam_addr];

    // CHR ROM model: one enabled cycle of read latency
    always @(posedge clk) begin
        if (clk_en && bus8.chr_re) begin
            bus8.chr_data_lo <= chr_f(bus8.chr_addr_lo);
            bus8.chr_data_hi <= chr_f(bus8.chr_addr_hi);
        end
        if (clk_en && bus16.chr_re) begin
            bus16.chr_data_lo <= chr_f(bus16.chr_addr_lo);
            bus16.chr_data_hi <= chr_f(bus16.chr_addr_hi);
        end
    end

    // Mid-cycle monitor of enabled cycles
    int          n8, n16;
    second_oam_t wd8 [16];
    second_oam_t wd16 [32];
    int          wi8 [16], wc8 [16], wi16 [32], wc16 [32];
    logic        ovf8_at [341];
    logic        spr0_at [341];
    logic        re16_at [341];
    logic [1:0]  st16_at [341];
    logic [12:0] alo_at [341];
    logic [12:0] ahi_at [341];

    always @(negedge clk) begin
        if (clk_en && rst_n && col <= 9'd340) begin
            ovf8_at[col] = ovf8;
            spr0_at[col] = spr0_8;
            re16_at[col] = bus16.chr_re;
            st16_at[col] = dut16.r_state;
            alo_at[col]  = bus8.chr_addr_lo;
            ahi_at[col]  = bus8.chr_addr_hi;
            if (bus8.line_wr) begin
                if (n8 < 16) begin
                    wd8[n8] = bus8.line_wr_data;
                    wi8[n8] = int'(bus8.line_wr_idx);
                    wc8[n8] = int'(col);
                end
                n8++;
            end
            if (bus16.line_wr) begin
                if (n16 < 32) begin
                    wd16[n16] = bus16.line_wr_data;
                    wi16[n16] = int'(bus16.line_wr_idx);
                    wc16[n16] = int'(col);
                end
                n16++;
            end
        end
    end

    function automatic logic [12:0] exp_addr(input logic [8:0] r, input logic [7:0] y,
                                             input logic [7:0] tile, input logic [7:0] attr,
                                             input bit tl, input pattern_tbl_t p);
        int d;
        d = (int'(r) - int'(y)) & 15;
        if (attr[7]) d = (tl ? 15 : 7) - d;
        if (tl) return 13'((int'(tile) & 1) * 4096 + (int'(tile) & 254) * 16 + (d >= 8 ? 16 : 0) + (d & 7));
        return 13'((p == RIGHT_TBL ? 4096 : 0) + int'(tile) * 16 + d);
    endfunction

    function automatic second_oam_t exp_slot(input logic [8:0] r, input int n, input bit tl,
                                             input pattern_tbl_t p);
        second_oam_t s;
        logic [12:0] a;
        a = exp_addr(r, oam[4*n], oam[4*n+1], oam[4*n+2], tl, p);
        s.active    = 1'b1;
        s.y_pos     = oam[4*n];
        s.tile_idx  = oam[4*n+1];
        s.attribute = oam[4*n+2];
        s.x_pos     = oam[4*n+3];
        s.bitmap_lo = chr_f(a);
        s.bitmap_hi = chr_f(a + 13'd8);
        return s;
    endfunction

    task automatic clear_oam();
        for (int n = 0; n < 64; n++) begin
            oam[4*n]   = 8'hF0;
            oam[4*n+1] = 8'(n);
            oam[4*n+2] = 8'(n * 5) & 8'h63;
            oam[4*n+3] = 8'(n * 3);
        end
    endtask

    task automatic tick(input logic [8:0] r, input logic [8:0] c, input bit gap);
        if (gap) begin
            clk_en = 1'b0; row = r; col = c;
            @(posedge clk); #1;
        end
        clk_en = 1'b1; row = r; col = c;
        @(posedge clk); #1;
    endtask

    task automatic run_line(input logic [8:0] r, input bit gaps);
        n8 = 0; n16 = 0;
        for (int c = 0; c <= 340; c++) tick(r, 9'(c), gaps && ($urandom_range(0, 3) == 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf8); end
        total++; if (spr0_8 !== 1'b0) begin bad++; $display("FAIL reset_spr0 got=%b exp=0", spr0_8); end
        total++; if ({bus8.line_wr, bus8.chr_re, bus8.oam_addr} !== 10'd0) begin
            bad++; $display("FAIL reset_bus got=%b/%b/%h exp=0", bus8.line_wr, bus8.chr_re, bus8.oam_addr); end
        total++; if ({bus16.line_wr_data, bus16.chr_addr_lo} !== '0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", bus16.line_wr_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sparse();
        int idx [3] = '{3, 10, 20};
        int act;
        second_oam_t e;
        clear_oam();
        oam[12] = 8'd45; oam[40] = 8'd45; oam[80] = 8'd45;
        tall = 1'b0; patt = LEFT_TBL;
        run_line(9'd50, 1'b0);
        total++; if (n8 !== 8) begin bad++; $display("FAIL t1_nwr got=%0d exp=8", n8); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (wi8[k] !== k || wc8[k] !== 258 + 2*k) begin
                bad++; $display("FAIL t1_order%0d got=idx%0d col%0d exp=idx%0d col%0d", k, wi8[k], wc8[k], k, 258+2*k); end
            total++;
            if (k < 3) begin
                e = exp_slot(9'd50, idx[k], 1'b0, LEFT_TBL);
                if (wd8[k] !== e) begin bad++; $display("FAIL t1_slot%0d got=%h exp=%h", k, wd8[k], e); end
            end else if ({wd8[k].active, wd8[k].bitmap_hi, wd8[k].bitmap_lo} !== 17'd0) begin
                bad++; $display("FAIL t1_inact%0d got=%h exp=0", k, wd8[k]);
            end
        end
        // Low bitplane address of the first slot: tile 3, row offset 5
        total++; if (alo_at[257] !== 13'h0035) begin bad++; $display("FAIL t1_addr got=%h exp=0035", alo_at[257]); end
        total++; if (ovf8_at[340] !== 1'b0 || spr0_at[257] !== 1'b0) begin
            bad++; $display("FAIL t1_flags got=%b%b exp=00", ovf8_at[340], spr0_at[257]); end
        act = 0;
        for (int k = 0; k < 16; k++) act += int'(wd16[k].active);
        total++; if (n16 !== 16 || act !== 3) begin bad++; $display("FAIL t1_dut16 got=%0d/%0d exp=16/3", n16, act); end
    endtask

    task automatic test_flip_right();
        second_oam_t e;
        clear_oam();
        oam[0] = 8'd20; oam[1] = 8'h12; oam[2] = 8'h80; oam[3] = 8'h40;
        tall = 1'b0; patt = RIGHT_TBL;
        run_line(9'd20, 1'b0);
        total++; if (alo_at[257] !== 13'h1127) begin bad++; $display("FAIL t3_lo got=%h exp=1127", alo_at[257]); end
        total++; if (ahi_at[257] !== 13'h112F) begin bad++; $display("FAIL t3_hi got=%h exp=112F", ahi_at[257]); end
        total++; if (spr0_at[256] !== 1'b0 || spr0_at[257] !== 1'b1) begin
            bad++; $display("FAIL t3_spr0 got=%b%b exp=01", spr0_at[256], spr0_at[257]); end
        e = '{1'b1, 8'd20, 8'h12, 8'h80, 8'h40, chr_f(13'h112F), chr_f(13'h1127)};
        total++; if (wd8[0] !== e) begin bad++; $display("FAIL t3_slot got=%h exp=%h", wd8[0], e); end
    endtask

    task automatic test_tall();
        int act;
        second_oam_t e;
        clear_oam();
        oam[0] = 8'd20; oam[1] = 8'h35; oam[2] = 8'h00;
        oam[4] = 8'd14; oam[8] = 8'd15;
        tall = 1'b1; patt = RIGHT_TBL;
        run_line(9'd30, 1'b0);
        // 8x16 address: bank from tile[0], tile pair base, half select, row
        total++; if (alo_at[257] !== 13'h1352) begin bad++; $display("FAIL t4_lo got=%h exp=1352", alo_at[257]); end
        total++; if (ahi_at[257] !== 13'h135A) begin bad++; $display("FAIL t4_hi got=%h exp=135A", ahi_at[257]); end
        act = 0;
        for (int k = 0; k < 8; k++) act += int'(wd8[k].active);
        e = exp_slot(9'd30, 2, 1'b1, RIGHT_TBL);
        total++; if (act !== 2 || wd8[1] !== e) begin
            bad++; $display("FAIL t4_slots got=%0d/%h exp=2/%h", act, wd8[1], e); end
        oam[2] = 8'h80;
        run_line(9'd30, 1'b0);
        total++; if (alo_at[257] !== 13'h1345 || ahi_at[257] !== 13'h134D) begin
            bad++; $display("FAIL t4_flip got=%h/%h exp=1345/134D", alo_at[257], ahi_at[257]); end
        tall = 1'b0;
    endtask

    task automatic test_overflow();
        int act;
        bit ok;
        clear_oam();
        for (int n = 0; n < 10; n++) oam[4*n] = 8'd96;
        patt = LEFT_TBL;
        run_line(9'd100, 1'b0);
        ok = (n8 == 8);
        for (int k = 0; k < 8; k++) ok &= (wd8[k] === exp_slot(9'd100, k, 1'b0, LEFT_TBL));
        total++; if (!ok) begin bad++; $display("FAIL t2_slots got=n%0d slot7=%h exp=8 full slots", n8, wd8[7]); end
        total++; if (ovf8_at[33] !== 1'b0 || ovf8_at[34] !== 1'b1) begin
            bad++; $display("FAIL t2_ovf_edge got=%b%b exp=01", ovf8_at[33], ovf8_at[34]); end
        act = 0;
        for (int k = 0; k < 16; k++) act += int'(wd16[k].active);
        total++; if (act !== 10 || ovf16 !== 1'b0) begin bad++; $display("FAIL t2_dut16 got=%0d/%b exp=10/0", act, ovf16); end
        run_line(9'd245, 1'b0);
        total++; if (n8 !== 0 || n16 !== 0 || ovf8 !== 1'b1) begin
            bad++; $display("FAIL t2_vblank got=%0d/%0d/%b exp=0/0/1", n8, n16, ovf8); end
        // y=$FF would be in range of row 261 if that line collected anything
        oam[20] = 8'hFF;
        run_line(9'd261, 1'b0);
        total++; if (ovf8_at[1] !== 1'b1 || ovf8_at[2] !== 1'b0) begin
            bad++; $display("FAIL t2_clear got=%b%b exp=10", ovf8_at[1], ovf8_at[2]); end
        act = 0;
        for (int k = 0; k < 8; k++) act += int'(wd8[k].active);
        for (int k = 0; k < 16; k++) act += int'(wd16[k].active);
        total++; if (n8 !== 8 || n16 !== 16 || act !== 0) begin
            bad++; $display("FAIL t2_pre got=%0d/%0d/%0d exp=8/16/0", n8, n16, act); end
    endtask

    task automatic test_max16();
        bit ok;
        clear_oam();
        for (int n = 0; n < 16; n++) oam[4*n] = 8'd96;
        run_line(9'd100, 1'b0);
        ok = (n16 == 16);
        for (int k = 0; k < 16; k++)
            ok &= (wi16[k] == k) && (wc16[k] == 258 + 2*k) && (wd16[k] === exp_slot(9'd100, k, 1'b0, LEFT_TBL));
        total++; if (!ok) begin bad++; $display("FAIL t5_writes got=n%0d lastcol%0d exp=16 288", n16, wc16[15]); end
        total++; if (st16_at[289] !== 2'd3 || re16_at[289] !== 1'b0 || re16_at[287] !== 1'b1) begin
            bad++; $display("FAIL t5_done got=%0d/%b/%b exp=3/0/1", st16_at[289], re16_at[289], re16_at[287]); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL t5_ovf got=%b exp=0", ovf16); end
    endtask

    task automatic test_reset_midline();
        int act;
        second_oam_t e0, e1;
        clear_oam();
        for (int n = 0; n < 5; n++) oam[4*n] = 8'd8;
        n8 = 0; n16 = 0;
        for (int c = 0; c <= 150; c++) tick(9'd10, 9'(c), 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (ovf8 !== 1'b0 || spr0_8 !== 1'b0 || bus8.oam_addr !== 8'd0 || bus8.line_wr !== 1'b0) begin
            bad++; $display("FAIL t6_rst got=%b/%b/%h/%b exp=0/0/00/0", ovf8, spr0_8, bus8.oam_addr, bus8.line_wr); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 151; c <= 340; c++) tick(9'd10, 9'(c), 1'b0);
        total++; if (n8 !== 0 || n16 !== 0) begin bad++; $display("FAIL t6_abort got=%0d/%0d exp=0/0", n8, n16); end
        clear_oam();
        oam[28] = 8'd5; oam[30] = 8'hC1; oam[120] = 8'd5; oam[122] = 8'h02;
        run_line(9'd11, 1'b1);
        e0 = exp_slot(9'd11, 7, 1'b0, LEFT_TBL);
        e1 = exp_slot(9'd11, 30, 1'b0, LEFT_TBL);
        total++; if (n8 !== 8 || wd8[0] !== e0 || wd8[1] !== e1) begin
            bad++; $display("FAIL t6_slots got=%0d/%h/%h exp=8/%h/%h", n8, wd8[0], wd8[1], e0, e1); end
        act = 0;
        for (int k = 0; k < 8; k++) act += int'(wd8[k].active);
        for (int k = 0; k < 16; k++) act += int'(wd16[k].active);
        total++; if (act !== 4 || n16 !== 16) begin bad++; $display("FAIL t6_active got=%0d/%0d exp=4/16", act, n16); end
    endtask

    task automatic test_boundary();
        int act;
        clear_oam();
        oam[16] = 8'd239; oam[20] = 8'hFF; oam[24] = 8'd240; oam[28] = 8'd232; oam[32] = 8'd231;
        run_line(9'd239, 1'b0);
        act = 0;
        for (int k = 0; k < 8; k++) act += int'(wd8[k].active);
        total++; if (act !== 2 || wd8[0].tile_idx !== 8'd4 || wd8[1].tile_idx !== 8'd7) begin
            bad++; $display("FAIL bnd_match got=%0d/%h/%h exp=2/04/07", act, wd8[0].tile_idx, wd8[1].tile_idx); end
        total++; if (wd8[0].bitmap_lo !== chr_f(13'h0040)) begin
            bad++; $display("FAIL bnd_diff0 got=%h exp=%h", wd8[0].bitmap_lo, chr_f(13'h0040)); end
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; row = '0; col = '0; tall = 1'b0; patt = LEFT_TBL;
        n8 = 0; n16 = 0;
        clear_oam();
        test_reset();
        test_sparse();
        test_flip_right();
        test_tall();
        test_overflow();
        test_max16();
        test_reset_midline();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
